mem_arbiter: RTL and testbench

//  Shares the single data-memory port between the instruction-fetch (IF) and load/store (LS) requesters of the RV64 core.

---
 rtl/npc_mem_pkg.sv | 22 ++
 rtl/mem_arb_grant.sv | 42 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | npc_mem_pkg : shared encodings for the memory-port arbiter       |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package npc_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  function automatic int mask_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_grant : LS-priority grant with IF starvation counter     |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module mem_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req_valid,
  input  logic ls_req_valid,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starve_hit;

  // IF is forced only when it is actually waiting and LS has used up its run.
  assign starve_hit = if_req_valid && (starve_cnt == C_STARVE_MAX);
  assign grant_ls   = en && ls_req_valid && !starve_hit;
  assign grant_if   = en && if_req_valid && !grant_ls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_ls) begin
      if (!if_req_valid)
        starve_cnt <= 4'd0;
      else if (starve_cnt != C_STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : shares one memory port between IF and LS requesters|
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_req_valid,
  output logic                          if_req_ready,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_resp_valid,
  output logic [DATA_W-1:0]             if_rdata,
  input  logic                          ls_req_valid,
  output logic                          ls_req_ready,
  input  logic [ADDR_W-1:0]             ls_addr,
  input  logic                          ls_we,
  input  logic [DATA_W-1:0]             ls_wdata,
  input  logic [mask_width(DATA_W)-1:0] ls_wmask,
  output logic                          ls_resp_valid,
  output logic [DATA_W-1:0]             ls_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [mask_width(DATA_W)-1:0] mem_wmask,
  input  logic                          mem_resp_valid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          resp_err
);

  localparam int MASK_W = mask_width(DATA_W);

  arb_state_e state;
  logic       owner;
  logic       grant_if;
  logic       grant_ls;
  logic       grant_en;
  logic       resp_fire;

  // Gating with rst keeps every combinational output at 0 while reset is held.
  assign grant_en = rst && (state == ARB_IDLE);

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk          (clk),
    .rst          (rst),
    .en           (grant_en),
    .if_req_valid (if_req_valid),
    .ls_req_valid (ls_req_valid),
    .grant_if     (grant_if),
    .grant_ls     (grant_ls)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_ls) begin
            owner     <= OWN_LS;
            mem_addr  <= ls_addr;
            mem_we    <= ls_we;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            state     <= ARB_REQ;
          end else if (grant_if) begin
            owner     <= OWN_IF;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= MASK_W'(0);
            state     <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready)
            state <= ARB_RESP;
        end
        ARB_RESP: begin
          if (mem_resp_valid)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign mem_req_valid = (state == ARB_REQ);

  assign resp_fire     = rst && (state == ARB_RESP) && mem_resp_valid;
  assign if_resp_valid = resp_fire && (owner == OWN_IF);
  assign ls_resp_valid = resp_fire && (owner == OWN_LS);
  assign resp_err      = rst && mem_resp_valid && (state != ARB_RESP);

  assign if_rdata = (rst && owner == OWN_IF) ? mem_rdata : '0;
  assign ls_rdata = (rst && owner == OWN_LS) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : directed self-checking bench for mem_arbiter    |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_resp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [63:0] ls_addr = '0;
  logic        ls_we = 1'b0;
  logic [63:0] ls_wdata = '0;
  logic [7:0]  ls_wmask = '0;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        resp_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .STARVE_MAX (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_rdata       (if_rdata),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_addr        (ls_addr),
    .ls_we          (ls_we),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_rdata       (ls_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .resp_err       (resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round with both requesters valid; reports who won.
  task automatic both_txn(output logic won_ls);
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    ls_we        = 1'b0;
    #1;
    chk("t3_one_ready", 64'(if_req_ready ^ ls_req_ready), 64'd1);
    won_ls = ls_req_ready;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h55;
    #1;
    chk("t3_resp_route", 64'(ls_resp_valid), 64'(won_ls));
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic won;
    logic [63:0] exp_addr;

    // Reset: all outputs 0 even with a request and read data pending
    if_req_valid = 1'b1;
    mem_rdata    = 64'hABCD;
    #3;
    chk("rst_if_ready",  64'(if_req_ready),  64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr",  mem_addr,           64'd0);
    chk("rst_if_rdata",  if_rdata,           64'd0);
    tick();
    tick();
    if_req_valid = 1'b0;
    rst          = 1'b1;

    // Test 1: IF-only read
    if_req_valid  = 1'b1;
    if_addr       = 64'h8000_0000;
    mem_req_ready = 1'b1;
    #1;
    chk("t1_if_ready_T0",  64'(if_req_ready),  64'd1);
    chk("t1_ls_ready_T0",  64'(ls_req_ready),  64'd0);
    chk("t1_mem_valid_T0", 64'(mem_req_valid), 64'd0);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("t1_mem_valid_T1", 64'(mem_req_valid), 64'd1);
    chk("t1_mem_addr_T1",  mem_addr,           64'h8000_0000);
    chk("t1_mem_we_T1",    64'(mem_we),        64'd0);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h13;
    #1;
    chk("t1_if_resp_T2",  64'(if_resp_valid), 64'd1);
    chk("t1_if_rdata_T2", if_rdata,           64'h13);
    chk("t1_ls_resp_T2",  64'(ls_resp_valid), 64'd0);
    chk("t1_err_T2",      64'(resp_err),      64'd0);
    tick();
    mem_resp_valid = 1'b0;

    // Test 2: simultaneous IF and LS store; LS wins first
    if_req_valid = 1'b1;
    if_addr      = 64'h8000_0004;
    ls_req_valid = 1'b1;
    ls_addr      = 64'h8000_1000;
    ls_we        = 1'b1;
    ls_wdata     = 64'hDEAD_BEEF;
    ls_wmask     = 8'hFF;
    #1;
    chk("t2_ls_ready", 64'(ls_req_ready), 64'd1);
    chk("t2_if_ready", 64'(if_req_ready), 64'd0);
    tick();
    ls_req_valid = 1'b0;
    #1;
    chk("t2_mem_we",    64'(mem_we),    64'd1);
    chk("t2_mem_addr",  mem_addr,       64'h8000_1000);
    chk("t2_mem_wdata", mem_wdata,      64'hDEAD_BEEF);
    chk("t2_mem_wmask", 64'(mem_wmask), 64'hFF);
    chk("t2_if_wait",   64'(if_req_ready), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    chk("t2_ls_ack", 64'(ls_resp_valid), 64'd1);
    chk("t2_if_ack", 64'(if_resp_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t2_if_next", 64'(if_req_ready), 64'd1);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("t2_if_we",   64'(mem_we),    64'd0);
    chk("t2_if_mask", 64'(mem_wmask), 64'd0);
    chk("t2_if_addr", mem_addr,       64'h8000_0004);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;

    // Test 3: LS streams while IF waits; IF forced after 4 LS grants
    for (int i = 0; i < 5; i++) begin
      both_txn(won);
      chk($sformatf("t3_grant_%0d", i), 64'(won), (i < 4) ? 64'd1 : 64'd0);
    end
    chk("t3_starve_clr", 64'(dut.u_grant.starve_cnt), 64'd0);
    both_txn(won);
    chk("t3_ls_again", 64'(won), 64'd1);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    tick();

    // Test 4: memory stalls for 5 cycles; request held stable
    ls_req_valid = 1'b1;
    ls_addr      = 64'h8000_2000;
    ls_we        = 1'b0;
    exp_addr     = 64'h8000_2000;
    tick();
    if_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_valid_%0d", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("t4_addr_%0d", i),  mem_addr,           exp_addr);
      chk($sformatf("t4_ready_%0d", i), 64'(if_req_ready | ls_req_ready), 64'd0);
      tick();
    end
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h1234;
    #1;
    chk("t4_ls_rdata", ls_rdata, 64'h1234);
    chk("t4_if_rdata", if_rdata, 64'd0);
    tick();
    mem_resp_valid = 1'b0;

    // Test 5: stray response in IDLE
    mem_resp_valid = 1'b1;
    #1;
    chk("t5_err",     64'(resp_err),      64'd1);
    chk("t5_if_resp", 64'(if_resp_valid), 64'd0);
    chk("t5_ls_resp", 64'(ls_resp_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    if_req_valid   = 1'b1;
    if_addr        = 64'h8000_0100;
    #1;
    chk("t5_err_gone",   64'(resp_err),     64'd0);
    chk("t5_still_idle", 64'(if_req_ready), 64'd1);

    // Test 6: reset while in RESP drops the transaction
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst           = 1'b0;
    #1;
    chk("t6_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("t6_rst_mem_addr",  mem_addr,           64'd0);
    chk("t6_rst_if_ready",  64'(if_req_ready),  64'd0);
    chk("t6_rst_if_rdata",  if_rdata,           64'd0);
    tick();
    if_req_valid = 1'b0;
    rst          = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    chk("t6_err",     64'(resp_err),      64'd1);
    chk("t6_if_resp", 64'(if_resp_valid), 64'd0);
    chk("t6_ls_resp", 64'(ls_resp_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
